// File: rtl/nios_cpu_pio_edge_input.sv
// Avalon-MM PIO input port: synchroniser, per-bit edge capture (W1C), IRQ mask and level IRQ.
// Optional per-bit debounce filter is enabled by defining NIOS_CPU_PIO_DEBOUNCE_EN.
module nios_cpu_pio_edge_input #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned EDGE_TYPE    = 0,
  parameter int unsigned DEBOUNCE_CNT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] raw;
  logic [DATA_WIDTH-1:0] d;
  logic [DATA_WIDTH-1:0] d_prev_q;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  irq_q, irq_d;
  logic                  wr;
  logic                  unused_bits;

  assign unused_bits = ^{writedata, 16'(DEBOUNCE_CNT)};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];

`ifdef NIOS_CPU_PIO_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CNT - 1);

  logic [15:0]           db_cnt_q [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] filt_q;

  // A bit only follows the synchroniser after DEBOUNCE_CNT consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        if (raw[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          filt_q[i]   <= raw[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign d = filt_q;
`else
  assign d = raw;
`endif

  assign wr = chipselect & ~write_n;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = d & ~d_prev_q;
      1:       edge_det = ~d & d_prev_q;
      default: edge_det = d ^ d_prev_q;
    endcase
  end

  // Clear is applied before OR-ing new edges so a same-cycle edge wins over W1C.
  always_comb begin
    edge_capture_d = edge_capture_q;
    irqmask_d      = irqmask_q;
    if (wr && address == 2'd3) edge_capture_d = edge_capture_q & ~writedata[DATA_WIDTH-1:0];
    if (wr && address == 2'd2) irqmask_d = writedata[DATA_WIDTH-1:0];
    edge_capture_d = edge_capture_d | edge_det;
    irq_d          = |(edge_capture_d & irqmask_d);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d = 32'(d);
      2'd2:    readdata_d = 32'(irqmask_q);
      2'd3:    readdata_d = 32'(edge_capture_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_prev_q       <= '0;
      edge_capture_q <= '0;
      irqmask_q      <= '0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      d_prev_q       <= d;
      edge_capture_q <= edge_capture_d;
      irqmask_q      <= irqmask_d;
      readdata_q     <= readdata_d;
      irq_q          <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
